// File: rtl/riscv_decode_stage.sv
// Registered RV32I decode stage with optional M and Zicsr decode, placed between fetch and execute.
// One-deep output register: holds under backpressure, drops on flush, and counts issued illegal bundles.
`ifndef ALU_DEFINES
`define ALU_DEFINES
`define ALU_OP_WIDTH 4
`define ALU_ADD  4'd0
`define ALU_SUB  4'd1
`define ALU_XOR  4'd2
`define ALU_OR   4'd3
`define ALU_AND  4'd4
`define ALU_SLL  4'd5
`define ALU_SRL  4'd6
`define ALU_SRA  4'd7
`define ALU_SLT  4'd8
`define ALU_SLTU 4'd9
`define ALU_EQ   4'd10
`define ALU_NE   4'd11
`define ALU_LTS  4'd12
`define ALU_GES  4'd13
`define ALU_LTU  4'd14
`define ALU_GEU  4'd15
`endif

module riscv_decode_stage #(
   parameter int unsigned ENABLE_M   = 0,
   parameter int unsigned ENABLE_CSR = 1,
   parameter int unsigned CNT_W      = 16
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     flush_i,
   input  logic                     in_valid_i,
   output logic                     in_ready_o,
   input  logic [31:0]              instr_i,
   input  logic [31:0]              pc_i,
   output logic                     out_valid_o,
   input  logic                     out_ready_i,
   output logic [31:0]              out_instr_o,
   output logic [31:0]              out_pc_o,
   output logic [1:0]               ex_op_a_sel_o,
   output logic [2:0]               ex_op_b_sel_o,
   output logic [`ALU_OP_WIDTH-1:0] alu_op_o,
   output logic                     mem_req_o,
   output logic                     mem_we_o,
   output logic [2:0]               mem_size_o,
   output logic                     gpr_we_a_o,
   output logic [1:0]               wb_src_sel_o,
   output logic [2:0]               mdu_op_o,
   output logic [2:0]               csr_op_o,
   output logic                     branch_o,
   output logic                     jal_o,
   output logic                     jalr_o,
   output logic                     illegal_instr_o,
   output logic [CNT_W-1:0]         illegal_cnt_o
);
   localparam logic [6:0] OPC_LOAD     = 7'b0000011;
   localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
   localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
   localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
   localparam logic [6:0] OPC_STORE    = 7'b0100011;
   localparam logic [6:0] OPC_OP       = 7'b0110011;
   localparam logic [6:0] OPC_LUI      = 7'b0110111;
   localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
   localparam logic [6:0] OPC_JALR     = 7'b1100111;
   localparam logic [6:0] OPC_JAL      = 7'b1101111;
   localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

   typedef struct packed {
      logic [31:0]              instr;
      logic [31:0]              pc;
      logic [1:0]               op_a;
      logic [2:0]               op_b;
      logic [`ALU_OP_WIDTH-1:0] alu_op;
      logic                     mem_req;
      logic                     mem_we;
      logic [2:0]               mem_size;
      logic                     gpr_we;
      logic [1:0]               wb_src;
      logic [2:0]               mdu_op;
      logic [2:0]               csr_op;
      logic                     branch;
      logic                     jal;
      logic                     jalr;
      logic                     illegal;
   } bundle_t;

   bundle_t                  dec;
   bundle_t                  bundle_d, bundle_q;
   logic                     valid_d, valid_q;
   logic [CNT_W-1:0]         cnt_d, cnt_q;
   logic [6:0]               opc, funct7;
   logic [2:0]               funct3;
   logic [`ALU_OP_WIDTH-1:0] alu_base;
   logic                     accept;

   always_comb begin
      opc    = instr_i[6:0];
      funct3 = instr_i[14:12];
      funct7 = instr_i[31:25];
      unique case (funct3)
         3'b000:  alu_base = `ALU_ADD;
         3'b001:  alu_base = `ALU_SLL;
         3'b010:  alu_base = `ALU_SLT;
         3'b011:  alu_base = `ALU_SLTU;
         3'b100:  alu_base = `ALU_XOR;
         3'b101:  alu_base = `ALU_SRL;
         3'b110:  alu_base = `ALU_OR;
         default: alu_base = `ALU_AND;
      endcase

      dec        = '0;
      dec.instr  = instr_i;
      dec.pc     = pc_i;
      dec.alu_op = `ALU_ADD;
      if (instr_i[1:0] != 2'b11) begin
         dec.illegal = 1'b1;
      end else begin
         case (opc)
            OPC_OP: begin
               dec.gpr_we = 1'b1;
               if (funct7 == 7'b0000000) dec.alu_op = alu_base;
               else if (funct7 == 7'b0100000 && funct3 == 3'b000) dec.alu_op = `ALU_SUB;
               else if (funct7 == 7'b0100000 && funct3 == 3'b101) dec.alu_op = `ALU_SRA;
               else if (ENABLE_M != 0 && funct7 == 7'b0000001) begin
                  dec.wb_src = 2'd2;
                  dec.mdu_op = funct3;
               end else dec.illegal = 1'b1;
            end
            OPC_OP_IMM: begin
               dec.op_b   = 3'd1;
               dec.gpr_we = 1'b1;
               dec.alu_op = alu_base;
               if (funct3 == 3'b001 && funct7 != 7'b0000000) dec.illegal = 1'b1;
               if (funct3 == 3'b101) begin
                  if (funct7 == 7'b0100000) dec.alu_op = `ALU_SRA;
                  else if (funct7 != 7'b0000000) dec.illegal = 1'b1;
               end
            end
            OPC_LUI:   begin dec.op_a = 2'd2; dec.op_b = 3'd2; dec.gpr_we = 1'b1; end
            OPC_AUIPC: begin dec.op_a = 2'd1; dec.op_b = 3'd2; dec.gpr_we = 1'b1; end
            OPC_LOAD: begin
               dec.op_b     = 3'd1;
               dec.mem_req  = 1'b1;
               dec.mem_size = funct3;
               dec.gpr_we   = 1'b1;
               dec.wb_src   = 2'd1;
               dec.illegal  = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
            end
            OPC_STORE: begin
               dec.op_b     = 3'd3;
               dec.mem_req  = 1'b1;
               dec.mem_we   = 1'b1;
               dec.mem_size = funct3;
               dec.illegal  = funct3[2] || (funct3 == 3'b011);
            end
            OPC_BRANCH: begin
               dec.branch = 1'b1;
               case (funct3)
                  3'b000:  dec.alu_op = `ALU_EQ;
                  3'b001:  dec.alu_op = `ALU_NE;
                  3'b100:  dec.alu_op = `ALU_LTS;
                  3'b101:  dec.alu_op = `ALU_GES;
                  3'b110:  dec.alu_op = `ALU_LTU;
                  3'b111:  dec.alu_op = `ALU_GEU;
                  default: dec.illegal = 1'b1;
               endcase
            end
            OPC_JAL:  begin dec.op_a = 2'd1; dec.op_b = 3'd4; dec.jal = 1'b1; dec.gpr_we = 1'b1; end
            OPC_JALR: begin
               dec.op_a    = 2'd1;
               dec.op_b    = 3'd4;
               dec.jalr    = 1'b1;
               dec.gpr_we  = 1'b1;
               dec.illegal = (funct3 != 3'b000);
            end
            OPC_MISC_MEM: dec.illegal = 1'b0;
            OPC_SYSTEM: begin
               if (funct3 == 3'b000) begin
                  dec.illegal = (instr_i != 32'h0000_0073) && (instr_i != 32'h0010_0073);
               end else if (ENABLE_CSR != 0) begin
                  dec.gpr_we = 1'b1;
                  dec.wb_src = 2'd3;
                  dec.csr_op = funct3;
               end else dec.illegal = 1'b1;
            end
            default: dec.illegal = 1'b1;
         endcase
      end
      // An illegal bundle must not cause any side effect downstream.
      if (dec.illegal) begin
         dec         = '0;
         dec.instr   = instr_i;
         dec.pc      = pc_i;
         dec.illegal = 1'b1;
      end
   end

   assign in_ready_o = !valid_q || out_ready_i;
   assign accept     = in_valid_i && in_ready_o && !flush_i;

   always_comb begin
      valid_d  = valid_q;
      bundle_d = bundle_q;
      cnt_d    = cnt_q;
      if (flush_i) valid_d = 1'b0;
      else if (in_ready_o) valid_d = accept;
      if (accept) bundle_d = dec;
      if (valid_q && out_ready_i && bundle_q.illegal && !flush_i && !(&cnt_q))
         cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid_q  <= 1'b0;
         bundle_q <= '0;
         cnt_q    <= '0;
      end else begin
         valid_q  <= valid_d;
         bundle_q <= bundle_d;
         cnt_q    <= cnt_d;
      end
   end

   assign out_valid_o     = valid_q;
   assign out_instr_o     = bundle_q.instr;
   assign out_pc_o        = bundle_q.pc;
   assign ex_op_a_sel_o   = bundle_q.op_a;
   assign ex_op_b_sel_o   = bundle_q.op_b;
   assign alu_op_o        = bundle_q.alu_op;
   assign mem_req_o       = bundle_q.mem_req;
   assign mem_we_o        = bundle_q.mem_we;
   assign mem_size_o      = bundle_q.mem_size;
   assign gpr_we_a_o      = bundle_q.gpr_we;
   assign wb_src_sel_o    = bundle_q.wb_src;
   assign mdu_op_o        = bundle_q.mdu_op;
   assign csr_op_o        = bundle_q.csr_op;
   assign branch_o        = bundle_q.branch;
   assign jal_o           = bundle_q.jal;
   assign jalr_o          = bundle_q.jalr;
   assign illegal_instr_o = bundle_q.illegal;
   assign illegal_cnt_o   = cnt_q;
endmodule

// File: tb/tb_riscv_decode_stage.sv
// Bench for riscv_decode_stage: two instances (M off / 16-bit count, M on / 3-bit count)
// share one stimulus stream and are checked against a table-driven decode and handshake model.
`timescale 1ns/1ps
`ifndef ALU_DEFINES
`define ALU_DEFINES
`define ALU_OP_WIDTH 4
`define ALU_ADD  4'd0
`define ALU_SUB  4'd1
`define ALU_XOR  4'd2
`define ALU_OR   4'd3
`define ALU_AND  4'd4
`define ALU_SLL  4'd5
`define ALU_SRL  4'd6
`define ALU_SRA  4'd7
`define ALU_SLT  4'd8
`define ALU_SLTU 4'd9
`define ALU_EQ   4'd10
`define ALU_NE   4'd11
`define ALU_LTS  4'd12
`define ALU_GES  4'd13
`define ALU_LTU  4'd14
`define ALU_GEU  4'd15
`endif

module tb_riscv_decode_stage;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, flush, in_valid, out_ready;
   logic [31:0] instr, pc;
   logic        in_rdy [2];
   logic        out_vld[2];
   logic [31:0] o_instr[2];
   logic [31:0] o_pc   [2];
   logic [1:0]  op_a   [2];
   logic [2:0]  op_b   [2];
   logic [`ALU_OP_WIDTH-1:0] alu[2];
   logic        mreq[2], mwe[2], gwe[2], br[2], jal[2], jalr[2], ill[2];
   logic [2:0]  msz[2], mdu[2], csr[2];
   logic [1:0]  wb [2];
   logic [15:0] cnt0;
   logic [2:0]  cnt1;

   riscv_decode_stage #(.ENABLE_M(0), .ENABLE_CSR(1), .CNT_W(16)) u_dut0 (
      .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(in_rdy[0]),
      .instr_i(instr), .pc_i(pc), .out_valid_o(out_vld[0]), .out_ready_i(out_ready),
      .out_instr_o(o_instr[0]), .out_pc_o(o_pc[0]), .ex_op_a_sel_o(op_a[0]), .ex_op_b_sel_o(op_b[0]),
      .alu_op_o(alu[0]), .mem_req_o(mreq[0]), .mem_we_o(mwe[0]), .mem_size_o(msz[0]),
      .gpr_we_a_o(gwe[0]), .wb_src_sel_o(wb[0]), .mdu_op_o(mdu[0]), .csr_op_o(csr[0]),
      .branch_o(br[0]), .jal_o(jal[0]), .jalr_o(jalr[0]), .illegal_instr_o(ill[0]),
      .illegal_cnt_o(cnt0));

   riscv_decode_stage #(.ENABLE_M(1), .ENABLE_CSR(1), .CNT_W(3)) u_dut1 (
      .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(in_rdy[1]),
      .instr_i(instr), .pc_i(pc), .out_valid_o(out_vld[1]), .out_ready_i(out_ready),
      .out_instr_o(o_instr[1]), .out_pc_o(o_pc[1]), .ex_op_a_sel_o(op_a[1]), .ex_op_b_sel_o(op_b[1]),
      .alu_op_o(alu[1]), .mem_req_o(mreq[1]), .mem_we_o(mwe[1]), .mem_size_o(msz[1]),
      .gpr_we_a_o(gwe[1]), .wb_src_sel_o(wb[1]), .mdu_op_o(mdu[1]), .csr_op_o(csr[1]),
      .branch_o(br[1]), .jal_o(jal[1]), .jalr_o(jalr[1]), .illegal_instr_o(ill[1]),
      .illegal_cnt_o(cnt1));

   typedef struct packed {
      logic [1:0] a;
      logic [2:0] b;
      logic [`ALU_OP_WIDTH-1:0] alu;
      logic mreq, mwe;
      logic [2:0] msz;
      logic gwe;
      logic [1:0] wb;
      logic [2:0] mdu, csr;
      logic br, jal, jalr, ill;
   } dec_t;

   localparam logic [3:0] BASE_TAB[8] = '{`ALU_ADD, `ALU_SLL, `ALU_SLT, `ALU_SLTU,
                                          `ALU_XOR, `ALU_SRL, `ALU_OR, `ALU_AND};
   localparam logic [3:0] BR_TAB[8]   = '{`ALU_EQ, `ALU_NE, `ALU_ADD, `ALU_ADD,
                                          `ALU_LTS, `ALU_GES, `ALU_LTU, `ALU_GEU};
   localparam logic [6:0] OPCS[12] = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h03, 7'h23,
                                       7'h63, 7'h6F, 7'h67, 7'h0F, 7'h73, 7'h2B};
   localparam logic [6:0] F7S[4]   = '{7'h00, 7'h20, 7'h01, 7'h7F};

   int          n_tests = 0;
   int          n_fail  = 0;
   logic        m_valid;
   logic [31:0] m_instr, m_pc;
   int          m_cnt0, m_cnt1;

   function automatic dec_t ref_decode(input logic [31:0] ins, input bit en_m);
      dec_t d;
      logic [2:0] f3;
      logic [6:0] f7;
      d = '0;
      f3 = ins[14:12];
      f7 = ins[31:25];
      if (ins[1:0] != 2'b11) d.ill = 1'b1;
      else case (ins[6:0])
         7'h33: begin
            d.gwe = 1'b1;
            if (en_m && f7 == 7'h01) begin d.wb = 2'd2; d.mdu = f3; end
            else if (f7 == 7'h00) d.alu = BASE_TAB[f3];
            else if (f7 == 7'h20 && f3 == 3'd0) d.alu = `ALU_SUB;
            else if (f7 == 7'h20 && f3 == 3'd5) d.alu = `ALU_SRA;
            else d.ill = 1'b1;
         end
         7'h13: begin
            d.b = 3'd1; d.gwe = 1'b1; d.alu = BASE_TAB[f3];
            if (f3 == 3'd1 && f7 != 7'h00) d.ill = 1'b1;
            if (f3 == 3'd5 && f7 == 7'h20) d.alu = `ALU_SRA;
            if (f3 == 3'd5 && f7 != 7'h20 && f7 != 7'h00) d.ill = 1'b1;
         end
         7'h37: begin d.a = 2'd2; d.b = 3'd2; d.gwe = 1'b1; end
         7'h17: begin d.a = 2'd1; d.b = 3'd2; d.gwe = 1'b1; end
         7'h03: begin
            d.b = 3'd1; d.mreq = 1'b1; d.msz = f3; d.gwe = 1'b1; d.wb = 2'd1;
            d.ill = !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
         end
         7'h23: begin d.b = 3'd3; d.mreq = 1'b1; d.mwe = 1'b1; d.msz = f3; d.ill = (f3 > 3'd2); end
         7'h63: begin d.br = 1'b1; d.alu = BR_TAB[f3]; d.ill = (f3 == 3'd2 || f3 == 3'd3); end
         7'h6F: begin d.a = 2'd1; d.b = 3'd4; d.jal = 1'b1; d.gwe = 1'b1; end
         7'h67: begin d.a = 2'd1; d.b = 3'd4; d.jalr = 1'b1; d.gwe = 1'b1; d.ill = (f3 != 3'd0); end
         7'h0F: d.ill = 1'b0;
         7'h73: begin
            if (f3 != 3'd0) begin d.gwe = 1'b1; d.wb = 2'd3; d.csr = f3; end
            else d.ill = !(ins == 32'h0000_0073 || ins == 32'h0010_0073);
         end
         default: d.ill = 1'b1;
      endcase
      if (d.ill) begin d = '0; d.ill = 1'b1; end
      return d;
   endfunction

   // Fields other than the forced-zero side effects are don't-care on an illegal bundle.
   function automatic dec_t obs(input int k);
      dec_t d;
      d = '{a: op_a[k], b: op_b[k], alu: alu[k], mreq: mreq[k], mwe: mwe[k], msz: msz[k],
            gwe: gwe[k], wb: wb[k], mdu: mdu[k], csr: csr[k], br: br[k], jal: jal[k],
            jalr: jalr[k], ill: ill[k]};
      if (d.ill) begin
         d.a = '0; d.b = '0; d.alu = '0; d.msz = '0; d.wb = '0; d.mdu = '0; d.csr = '0;
      end
      return d;
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [31:0] r;
      int unsigned sel;
      r = $urandom();
      sel = $urandom_range(0, 9);
      if (sel == 0) return r;
      if (sel == 1) return ($urandom_range(0, 1) == 1) ? 32'h0010_0073 : 32'h0000_0073;
      r[6:0]   = OPCS[$urandom_range(0, 11)];
      r[31:25] = F7S[$urandom_range(0, 3)];
      return r;
   endfunction

   task automatic drive(input logic r, input logic f, input logic iv, input logic [31:0] ins,
                        input logic [31:0] p, input logic ordy);
      rst = r; flush = f; in_valid = iv; instr = ins; pc = p; out_ready = ordy;
   endtask

   task automatic tick();
      dec_t d0, d1;
      @(posedge clk);
      if (rst) begin
         m_valid = 1'b0; m_cnt0 = 0; m_cnt1 = 0;
      end else begin
         if (m_valid && out_ready && !flush) begin
            d0 = ref_decode(m_instr, 1'b0);
            d1 = ref_decode(m_instr, 1'b1);
            if (d0.ill && m_cnt0 < 65535) m_cnt0++;
            if (d1.ill && m_cnt1 < 7) m_cnt1++;
         end
         if (flush) m_valid = 1'b0;
         else if (!m_valid || out_ready) begin
            m_valid = in_valid;
            if (in_valid) begin m_instr = instr; m_pc = pc; end
         end
      end
      #1;
   endtask

   task automatic test_reset();
      drive(1, 0, 0, 32'h0, 32'h0, 0); tick(); tick();
      drive(0, 0, 0, 32'h0, 32'h0, 1); #1;
      n_tests++;
      if (out_vld[0] !== 1'b0 || out_vld[1] !== 1'b0) begin
         n_fail++; $display("FAIL reset_valid: got %b/%b want 0", out_vld[0], out_vld[1]);
      end
      n_tests++;
      if ({o_instr[0], o_pc[0], op_a[0], op_b[0], alu[0], mreq[0], mwe[0], msz[0], gwe[0], wb[0],
           mdu[0], csr[0], br[0], jal[0], jalr[0], ill[0]} !== '0) begin
         n_fail++; $display("FAIL reset_bundle: got instr=%h pc=%h alu=%h ill=%b want all zero",
                            o_instr[0], o_pc[0], alu[0], ill[0]);
      end
      n_tests++;
      if (cnt0 !== 16'd0 || cnt1 !== 3'd0) begin
         n_fail++; $display("FAIL reset_cnt: got %0d/%0d want 0", cnt0, cnt1);
      end
      n_tests++;
      if (in_rdy[0] !== 1'b1) begin
         n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_rdy[0]);
      end
   endtask

   task automatic test_add();
      drive(0, 0, 1, 32'h0020_81B3, 32'h0000_1000, 1); tick();
      n_tests++;
      if ({out_vld[0], alu[0], op_a[0], op_b[0], gwe[0], wb[0], ill[0]} !==
          {1'b1, `ALU_ADD, 2'd0, 3'd0, 1'b1, 2'd0, 1'b0}) begin
         n_fail++; $display("FAIL add_bundle: got v=%b alu=%h a=%h b=%h we=%b wb=%h ill=%b want v=1 alu=0 a=0 b=0 we=1 wb=0 ill=0",
                            out_vld[0], alu[0], op_a[0], op_b[0], gwe[0], wb[0], ill[0]);
      end
      n_tests++;
      if (o_instr[0] !== 32'h0020_81B3 || o_pc[0] !== 32'h0000_1000) begin
         n_fail++; $display("FAIL add_regs: got instr=%h pc=%h want 002081b3/00001000", o_instr[0], o_pc[0]);
      end
      drive(0, 0, 0, 32'h0, 32'h0, 1); tick();
   endtask

   task automatic test_backpressure();
      drive(0, 0, 1, 32'h0000_A103, 32'h0000_2000, 0); tick();
      for (int i = 0; i < 3; i++) begin
         drive(0, 0, 1, 32'h0020_81B3, 32'h0000_3000 + 32'(i), 0); #1;
         n_tests++;
         if (in_rdy[0] !== 1'b0) begin
            n_fail++; $display("FAIL bp_in_ready[%0d]: got %b want 0", i, in_rdy[0]);
         end
         tick();
         n_tests++;
         if (out_vld[0] !== 1'b1 || o_instr[0] !== 32'h0000_A103 || o_pc[0] !== 32'h0000_2000) begin
            n_fail++; $display("FAIL bp_hold[%0d]: got v=%b instr=%h pc=%h want 1/0000a103/00002000",
                               i, out_vld[0], o_instr[0], o_pc[0]);
         end
      end
      drive(0, 0, 0, 32'h0, 32'h0, 1); #1;
      n_tests++;
      if (in_rdy[0] !== 1'b1) begin
         n_fail++; $display("FAIL bp_release_ready: got %b want 1", in_rdy[0]);
      end
      n_tests++;
      if ({mreq[0], mwe[0], msz[0], wb[0], gwe[0]} !== {1'b1, 1'b0, 3'b010, 2'd1, 1'b1}) begin
         n_fail++; $display("FAIL lw_bundle: got req=%b we=%b size=%b wb=%h gwe=%b want 1/0/010/1/1",
                            mreq[0], mwe[0], msz[0], wb[0], gwe[0]);
      end
      tick();
      n_tests++;
      if (out_vld[0] !== 1'b0) begin
         n_fail++; $display("FAIL bp_drain: got v=%b want 0", out_vld[0]);
      end
   endtask

   task automatic test_mul();
      drive(0, 0, 1, 32'h0220_81B3, 32'h0000_4000, 1); tick();
      n_tests++;
      if ({ill[0], gwe[0], mreq[0]} !== 3'b100) begin
         n_fail++; $display("FAIL mul_nom: got ill=%b gwe=%b req=%b want 1/0/0", ill[0], gwe[0], mreq[0]);
      end
      n_tests++;
      if ({ill[1], wb[1], mdu[1], gwe[1]} !== {1'b0, 2'd2, 3'd0, 1'b1}) begin
         n_fail++; $display("FAIL mul_m: got ill=%b wb=%h mdu=%h gwe=%b want 0/2/0/1", ill[1], wb[1], mdu[1], gwe[1]);
      end
      n_tests++;
      if (cnt0 !== 16'd0) begin
         n_fail++; $display("FAIL mul_cnt_before: got %0d want 0", cnt0);
      end
      drive(0, 0, 0, 32'h0, 32'h0, 1); tick();
      n_tests++;
      if (cnt0 !== 16'd1 || cnt1 !== 3'd0) begin
         n_fail++; $display("FAIL mul_cnt_after: got %0d/%0d want 1/0", cnt0, cnt1);
      end
   endtask

   task automatic test_flush();
      drive(0, 0, 1, 32'hFFFF_FFFF, 32'h0000_5000, 0); tick();
      drive(0, 1, 1, 32'h0020_81B3, 32'h0000_5004, 0); tick();
      n_tests++;
      if (out_vld[0] !== 1'b0 || cnt0 !== 16'd1) begin
         n_fail++; $display("FAIL flush_held: got v=%b cnt=%0d want 0/1", out_vld[0], cnt0);
      end
      drive(0, 0, 0, 32'h0, 32'h0, 1); tick();
      n_tests++;
      if (out_vld[0] !== 1'b0 || cnt0 !== 16'd1) begin
         n_fail++; $display("FAIL flush_nocapture: got v=%b cnt=%0d want 0/1", out_vld[0], cnt0);
      end
      drive(0, 0, 1, 32'hFFFF_FFFF, 32'h0000_5008, 1); tick();
      drive(0, 1, 0, 32'h0, 32'h0, 1); tick();
      n_tests++;
      if (out_vld[0] !== 1'b0 || cnt0 !== 16'd1 || cnt1 !== 3'd0) begin
         n_fail++; $display("FAIL flush_handshake: got v=%b cnt=%0d/%0d want 0/1/0", out_vld[0], cnt0, cnt1);
      end
   endtask

   task automatic test_saturate();
      for (int i = 0; i < 10; i++) begin
         drive(0, 0, 1, 32'hFFFF_FFFF, 32'h0000_7000 + 32'(4 * i), 1); tick();
         n_tests++;
         if (ill[1] !== 1'b1 || out_vld[1] !== 1'b1) begin
            n_fail++; $display("FAIL sat_ill[%0d]: got ill=%b v=%b want 1/1", i, ill[1], out_vld[1]);
         end
      end
      drive(0, 0, 0, 32'h0, 32'h0, 1); tick();
      n_tests++;
      if (cnt1 !== 3'h7) begin
         n_fail++; $display("FAIL sat_cnt1: got %0d want 7", cnt1);
      end
      n_tests++;
      if (cnt0 !== 16'(m_cnt0)) begin
         n_fail++; $display("FAIL sat_cnt0: got %0d want %0d", cnt0, m_cnt0);
      end
   endtask

   task automatic test_random();
      logic exp_rdy;
      dec_t exp_d, got_d;
      for (int i = 0; i < 400; i++) begin
         drive(0, ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0), rand_instr(),
               $urandom(), ($urandom_range(0, 3) != 0));
         #1;
         exp_rdy = !m_valid || out_ready;
         for (int k = 0; k < 2; k++) begin
            n_tests++;
            if (in_rdy[k] !== exp_rdy) begin
               n_fail++; $display("FAIL rnd_ready[%0d] dut%0d: got %b want %b", i, k, in_rdy[k], exp_rdy);
            end
         end
         tick();
         for (int k = 0; k < 2; k++) begin
            n_tests++;
            if (out_vld[k] !== m_valid) begin
               n_fail++; $display("FAIL rnd_valid[%0d] dut%0d: got %b want %b", i, k, out_vld[k], m_valid);
            end
            if (m_valid) begin
               exp_d = ref_decode(m_instr, k == 1);
               got_d = obs(k);
               n_tests++;
               if (got_d !== exp_d || o_instr[k] !== m_instr || o_pc[k] !== m_pc) begin
                  n_fail++; $display("FAIL rnd_bundle[%0d] dut%0d instr=%h: got %h pc=%h want %h pc=%h",
                                     i, k, m_instr, got_d, o_pc[k], exp_d, m_pc);
               end
            end
         end
         n_tests++;
         if (cnt0 !== 16'(m_cnt0) || cnt1 !== 3'(m_cnt1)) begin
            n_fail++; $display("FAIL rnd_cnt[%0d]: got %0d/%0d want %0d/%0d", i, cnt0, cnt1, m_cnt0, m_cnt1);
         end
      end
   endtask

   task automatic test_reset_mid();
      drive(0, 0, 1, 32'hFFFF_FFFF, 32'h0000_6000, 0); tick();
      n_tests++;
      if (out_vld[0] !== 1'b1) begin
         n_fail++; $display("FAIL rstmid_pre: got v=%b want 1", out_vld[0]);
      end
      drive(1, 1, 1, 32'h0020_81B3, 32'h0000_6004, 0); tick();
      drive(0, 0, 0, 32'h0, 32'h0, 0); #1;
      n_tests++;
      if (out_vld[0] !== 1'b0 || cnt0 !== 16'd0 || cnt1 !== 3'd0) begin
         n_fail++; $display("FAIL rstmid_state: got v=%b cnt=%0d/%0d want 0/0/0", out_vld[0], cnt0, cnt1);
      end
      n_tests++;
      if ({o_instr[0], o_pc[0], op_a[0], op_b[0], alu[0], mreq[0], mwe[0], msz[0], gwe[0], wb[0],
           mdu[0], csr[0], br[0], jal[0], jalr[0], ill[0]} !== '0) begin
         n_fail++; $display("FAIL rstmid_bundle: got instr=%h pc=%h ill=%b want all zero",
                            o_instr[0], o_pc[0], ill[0]);
      end
   endtask

   initial begin
      m_valid = 1'b0; m_instr = '0; m_pc = '0; m_cnt0 = 0; m_cnt1 = 0;
      drive(1, 0, 0, 32'h0, 32'h0, 0);
      test_reset();
      test_add();
      test_backpressure();
      test_mul();
      test_flush();
      test_saturate();
      test_random();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
